// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select
// encodings, FSM state values, register index width and the match helper.
package pipeline_pkg;

   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_STALL    = 2'd1,
      HZ_MEM_WAIT = 2'd2
   } hz_state_e;

   // A read of x0 never depends on an older instruction.
   function automatic logic reg_hit(
      input logic              used,
      input logic              we,
      input logic [REG_AW-1:0] rd,
      input logic [REG_AW-1:0] rs
   );
      return used && we && (rd == rs) && (rs != '0);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/writeback/handshake bundle between the pipeline datapath (master)
// and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 32
) ();
   logic [pipeline_pkg::REG_AW-1:0] id_rs1, id_rs2;
   logic                            id_rs1_used, id_rs2_used;
   logic [pipeline_pkg::REG_AW-1:0] ex_rd, mem_rd, wb_rd;
   logic                            ex_reg_write, mem_reg_write, wb_reg_write;
   logic                            ex_mem_read;
   logic                            ex_redirect;
   logic                            mem_req, mem_ready;
   logic                            pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic                            ifid_flush, idex_flush;
   logic [1:0]                      fwd_a, fwd_b;
   logic [CNT_W-1:0]                stall_cycles;

   modport master (
      output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
      output ex_rd, mem_rd, wb_rd, ex_reg_write, mem_reg_write, wb_reg_write,
      output ex_mem_read, ex_redirect, mem_req, mem_ready,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
      input  ifid_flush, idex_flush, fwd_a, fwd_b, stall_cycles
   );

   modport slave (
      input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
      input  ex_rd, mem_rd, wb_rd, ex_reg_write, mem_reg_write, wb_reg_write,
      input  ex_mem_read, ex_redirect, mem_req, mem_ready,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
      output ifid_flush, idex_flush, fwd_a, fwd_b, stall_cycles
   );
endinterface

// File: rtl/forward_unit.sv
// Per-operand dependency match and ALU forward select.
// PIPE_FORWARD_EN enables forwarding; otherwise the select is tied to the register file.
module forward_unit
   import pipeline_pkg::*;
(
   input  logic [REG_AW-1:0] rs_i,
   input  logic              rs_used_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic              ex_we_i,
   input  logic [REG_AW-1:0] mem_rd_i,
   input  logic              mem_we_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic              wb_we_i,
   output logic              ex_match_o,
   output logic              mem_match_o,
   output logic [1:0]        fwd_o
);
   logic wb_match;

   assign ex_match_o  = reg_hit(rs_used_i, ex_we_i,  ex_rd_i,  rs_i);
   assign mem_match_o = reg_hit(rs_used_i, mem_we_i, mem_rd_i, rs_i);
   assign wb_match    = reg_hit(rs_used_i, wb_we_i,  wb_rd_i,  rs_i);

`ifdef PIPE_FORWARD_EN
   // The younger producer (MEM) wins over WB.
   always_comb begin
      fwd_o = FWD_RF;
      if (mem_match_o) begin
         fwd_o = FWD_MEM;
      end else if (wb_match) begin
         fwd_o = FWD_WB;
      end
   end
`else
   logic unused_wb_match;
   assign unused_wb_match = wb_match;
   assign fwd_o           = FWD_RF;
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
// PIPE_FORWARD_EN selects the forwarding build (load-use is the only RAW stall).
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input logic                 clk,
   input logic                 rst,
   pipeline_hazard_ctrl_if.slave bus
);
   localparam logic [1:0] ST_RUN      = HZ_RUN;
   localparam logic [1:0] ST_STALL    = HZ_STALL;
   localparam logic [1:0] ST_MEM_WAIT = HZ_MEM_WAIT;

   logic [1:0]       state_q, state_d;
   logic [1:0]       ret_q, ret_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   logic             ex_match_a, ex_match_b, mem_match_a, mem_match_b;
   logic [1:0]       fwd_a, fwd_b;
   logic [1:0]       raw_n;
   logic [1:0]       eff_state;
   logic             mem_wait;
   logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic             ifid_flush, idex_flush;

   forward_unit u_fwd_a (
      .rs_i       (bus.id_rs1),
      .rs_used_i  (bus.id_rs1_used),
      .ex_rd_i    (bus.ex_rd),
      .ex_we_i    (bus.ex_reg_write),
      .mem_rd_i   (bus.mem_rd),
      .mem_we_i   (bus.mem_reg_write),
      .wb_rd_i    (bus.wb_rd),
      .wb_we_i    (bus.wb_reg_write),
      .ex_match_o (ex_match_a),
      .mem_match_o(mem_match_a),
      .fwd_o      (fwd_a)
   );

   forward_unit u_fwd_b (
      .rs_i       (bus.id_rs2),
      .rs_used_i  (bus.id_rs2_used),
      .ex_rd_i    (bus.ex_rd),
      .ex_we_i    (bus.ex_reg_write),
      .mem_rd_i   (bus.mem_rd),
      .mem_we_i   (bus.mem_reg_write),
      .wb_rd_i    (bus.wb_rd),
      .wb_we_i    (bus.wb_reg_write),
      .ex_match_o (ex_match_b),
      .mem_match_o(mem_match_b),
      .fwd_o      (fwd_b)
   );

`ifdef PIPE_FORWARD_EN
   logic unused_mem_match;
   assign unused_mem_match = mem_match_a ^ mem_match_b;
   assign raw_n = ((ex_match_a || ex_match_b) && bus.ex_mem_read) ? 2'd1 : 2'd0;
`else
   logic unused_ex_mem_read;
   assign unused_ex_mem_read = bus.ex_mem_read;
   // WB writes the register file on the falling edge, so only EX/MEM producers stall.
   assign raw_n = (ex_match_a || ex_match_b)   ? 2'd2 :
                  (mem_match_a || mem_match_b) ? 2'd1 : 2'd0;
`endif

   // A memory wait parks the interrupted state in ret_q; once the wait ends
   // the controller behaves exactly as that state would.
   assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;
   assign mem_wait  = bus.mem_req && !bus.mem_ready;

   always_comb begin
      pc_en          = 1'b1;
      ifid_en        = 1'b1;
      idex_en        = 1'b1;
      exmem_en       = 1'b1;
      memwb_en       = 1'b1;
      ifid_flush     = 1'b0;
      idex_flush     = 1'b0;
      state_d        = ST_RUN;
      ret_d          = ret_q;
      cnt_d          = cnt_q;

      if (mem_wait) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
         state_d  = ST_MEM_WAIT;
         ret_d    = eff_state;
      end else if (bus.ex_redirect) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         cnt_d      = 2'd0;
      end else if (eff_state == ST_STALL) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
         cnt_d      = cnt_q - 2'd1;
         state_d    = (cnt_q == 2'd1) ? ST_RUN : ST_STALL;
      end else if (raw_n != 2'd0) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
         if (raw_n > 2'd1) begin
            cnt_d   = raw_n - 2'd1;
            state_d = ST_STALL;
         end
      end

      stall_cycles_d = stall_cycles_q;
      if (!pc_en) begin
         stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_RUN;
         ret_q          <= ST_RUN;
         cnt_q          <= 2'd0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         ret_q          <= ret_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   // Outputs are forced to the free-running pattern for as long as reset is held.
   assign bus.pc_en        = rst | pc_en;
   assign bus.ifid_en      = rst | ifid_en;
   assign bus.idex_en      = rst | idex_en;
   assign bus.exmem_en     = rst | exmem_en;
   assign bus.memwb_en     = rst | memwb_en;
   assign bus.ifid_flush   = !rst & ifid_flush;
   assign bus.idex_flush   = !rst & idex_flush;
   assign bus.fwd_a        = rst ? FWD_RF : fwd_a;
   assign bus.fwd_b        = rst ? FWD_RF : fwd_b;
   assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed checks of pipeline_hazard_ctrl; expectations follow the build
// selected by PIPE_FORWARD_EN.
module tb_pipeline_hazard_ctrl;
`ifdef PIPE_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   pipeline_hazard_ctrl_if #(.CNT_W(32)) bus ();
   pipeline_hazard_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
      bus.ex_rd = '0; bus.mem_rd = '0; bus.wb_rd = '0;
      bus.ex_reg_write = 1'b0; bus.mem_reg_write = 1'b0; bus.wb_reg_write = 1'b0;
      bus.ex_mem_read = 1'b0; bus.ex_redirect = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      bus.ex_rd = 5'd5; bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1;
      bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1;
      bus.mem_rd = 5'd5; bus.mem_reg_write = 1'b1; bus.mem_req = 1'b1;
      #2;
      tests++; if (bus.pc_en !== 1'b1) begin fails++; $display("FAIL rst_pc_en: got %b expected 1", bus.pc_en); end
      tests++; if (bus.memwb_en !== 1'b1) begin fails++; $display("FAIL rst_memwb_en: got %b expected 1", bus.memwb_en); end
      tests++; if (bus.idex_flush !== 1'b0) begin fails++; $display("FAIL rst_idex_flush: got %b expected 0", bus.idex_flush); end
      tests++; if (bus.fwd_a !== 2'b00) begin fails++; $display("FAIL rst_fwd_a: got %b expected 00", bus.fwd_a); end
      tests++; if (bus.stall_cycles !== 32'd0) begin fails++; $display("FAIL rst_stall_cycles: got %0d expected 0", bus.stall_cycles); end
      $display("[TB] reset: outputs held at free-running values");
      idle_inputs();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      bus.ex_rd = 5'd5; bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1;
      bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1;
      #2;
      tests++; if (bus.pc_en !== 1'b0) begin fails++; $display("FAIL lu_c0_pc_en: got %b expected 0", bus.pc_en); end
      tests++; if (bus.ifid_en !== 1'b0) begin fails++; $display("FAIL lu_c0_ifid_en: got %b expected 0", bus.ifid_en); end
      tests++; if (bus.idex_flush !== 1'b1) begin fails++; $display("FAIL lu_c0_idex_flush: got %b expected 1", bus.idex_flush); end
      tests++; if (bus.idex_en !== 1'b1) begin fails++; $display("FAIL lu_c0_idex_en: got %b expected 1", bus.idex_en); end
      tests++; if (bus.ifid_flush !== 1'b0) begin fails++; $display("FAIL lu_c0_ifid_flush: got %b expected 0", bus.ifid_flush); end
      tick();
      bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0; bus.mem_rd = 5'd5; bus.mem_reg_write = 1'b1;
      #2;
      tests++; if (bus.pc_en !== (FWD ? 1'b1 : 1'b0)) begin fails++; $display("FAIL lu_c1_pc_en: got %b expected %b", bus.pc_en, FWD ? 1'b1 : 1'b0); end
      tests++; if (bus.idex_flush !== (FWD ? 1'b0 : 1'b1)) begin fails++; $display("FAIL lu_c1_idex_flush: got %b expected %b", bus.idex_flush, FWD ? 1'b0 : 1'b1); end
      tests++; if (bus.stall_cycles !== 32'd1) begin fails++; $display("FAIL lu_c1_stall_cycles: got %0d expected 1", bus.stall_cycles); end
      tick();
      bus.mem_reg_write = 1'b0; bus.wb_rd = 5'd5; bus.wb_reg_write = 1'b1;
      #2;
      tests++; if (bus.pc_en !== 1'b1) begin fails++; $display("FAIL lu_c2_pc_en: got %b expected 1", bus.pc_en); end
      tests++; if (bus.fwd_a !== (FWD ? 2'b10 : 2'b00)) begin fails++; $display("FAIL lu_c2_fwd_a: got %b expected %b", bus.fwd_a, FWD ? 2'b10 : 2'b00); end
      tests++; if (bus.stall_cycles !== (FWD ? 32'd1 : 32'd2)) begin fails++; $display("FAIL lu_c2_stall_cycles: got %0d expected %0d", bus.stall_cycles, FWD ? 1 : 2); end
      $display("[TB] load_use: lw x5 -> add x5 sequence done");
   endtask

   task automatic test_alu_raw();
      do_reset();
      bus.ex_rd = 5'd3; bus.ex_reg_write = 1'b1; bus.id_rs2 = 5'd3; bus.id_rs2_used = 1'b1;
      #2;
      tests++; if (bus.pc_en !== (FWD ? 1'b1 : 1'b0)) begin fails++; $display("FAIL alu_c0_pc_en: got %b expected %b", bus.pc_en, FWD ? 1'b1 : 1'b0); end
      tick();
      bus.ex_reg_write = 1'b0; bus.mem_rd = 5'd3; bus.mem_reg_write = 1'b1;
      #2;
      tests++; if (bus.pc_en !== (FWD ? 1'b1 : 1'b0)) begin fails++; $display("FAIL alu_c1_pc_en: got %b expected %b", bus.pc_en, FWD ? 1'b1 : 1'b0); end
      tests++; if (bus.fwd_b !== (FWD ? 2'b01 : 2'b00)) begin fails++; $display("FAIL alu_c1_fwd_b: got %b expected %b", bus.fwd_b, FWD ? 2'b01 : 2'b00); end
      tick();
      bus.mem_reg_write = 1'b0; bus.wb_rd = 5'd3; bus.wb_reg_write = 1'b1;
      #2;
      tests++; if (bus.pc_en !== 1'b1) begin fails++; $display("FAIL alu_c2_pc_en: got %b expected 1", bus.pc_en); end
      tests++; if (bus.fwd_b !== (FWD ? 2'b10 : 2'b00)) begin fails++; $display("FAIL alu_c2_fwd_b: got %b expected %b", bus.fwd_b, FWD ? 2'b10 : 2'b00); end
      tests++; if (bus.stall_cycles !== (FWD ? 32'd0 : 32'd2)) begin fails++; $display("FAIL alu_c2_stall_cycles: got %0d expected %0d", bus.stall_cycles, FWD ? 0 : 2); end
      $display("[TB] alu_raw: add x3 -> use x3 sequence done");
   endtask

   task automatic test_mem_only();
      do_reset();
      bus.mem_rd = 5'd3; bus.mem_reg_write = 1'b1; bus.id_rs1 = 5'd3; bus.id_rs1_used = 1'b1;
      #2;
      tests++; if (bus.pc_en !== (FWD ? 1'b1 : 1'b0)) begin fails++; $display("FAIL memonly_c0_pc_en: got %b expected %b", bus.pc_en, FWD ? 1'b1 : 1'b0); end
      tests++; if (bus.fwd_a !== (FWD ? 2'b01 : 2'b00)) begin fails++; $display("FAIL memonly_c0_fwd_a: got %b expected %b", bus.fwd_a, FWD ? 2'b01 : 2'b00); end
      tick();
      bus.mem_reg_write = 1'b0; bus.wb_rd = 5'd3; bus.wb_reg_write = 1'b1;
      #2;
      tests++; if (bus.pc_en !== 1'b1) begin fails++; $display("FAIL memonly_c1_pc_en: got %b expected 1", bus.pc_en); end
      tests++; if (bus.stall_cycles !== (FWD ? 32'd0 : 32'd1)) begin fails++; $display("FAIL memonly_c1_stall_cycles: got %0d expected %0d", bus.stall_cycles, FWD ? 0 : 1); end
      $display("[TB] mem_only: MEM-stage producer done");
   endtask

   task automatic test_x0_and_unused();
      do_reset();
      bus.ex_rd = 5'd0; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0;
      bus.ex_reg_write = 1'b1; bus.mem_reg_write = 1'b1; bus.wb_reg_write = 1'b1; bus.ex_mem_read = 1'b1;
      bus.id_rs1_used = 1'b1; bus.id_rs2_used = 1'b1;
      #2;
      tests++; if (bus.pc_en !== 1'b1) begin fails++; $display("FAIL x0_pc_en: got %b expected 1", bus.pc_en); end
      tests++; if (bus.idex_flush !== 1'b0) begin fails++; $display("FAIL x0_idex_flush: got %b expected 0", bus.idex_flush); end
      tests++; if (bus.fwd_a !== 2'b00) begin fails++; $display("FAIL x0_fwd_a: got %b expected 00", bus.fwd_a); end
      tests++; if (bus.fwd_b !== 2'b00) begin fails++; $display("FAIL x0_fwd_b: got %b expected 00", bus.fwd_b); end
      tick();
      bus.ex_rd = 5'd5; bus.wb_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
      #2;
      tests++; if (bus.pc_en !== 1'b1) begin fails++; $display("FAIL unused_pc_en: got %b expected 1", bus.pc_en); end
      tests++; if (bus.fwd_a !== 2'b00) begin fails++; $display("FAIL unused_fwd_a: got %b expected 00", bus.fwd_a); end
      tick();
      tests++; if (bus.stall_cycles !== 32'd0) begin fails++; $display("FAIL x0_stall_cycles: got %0d expected 0", bus.stall_cycles); end
      $display("[TB] x0_and_unused: no false dependencies");
   endtask

   task automatic test_redirect();
      do_reset();
      bus.ex_rd = 5'd5; bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1;
      bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1; bus.ex_redirect = 1'b1;
      #2;
      tests++; if (bus.ifid_flush !== 1'b1) begin fails++; $display("FAIL redir_ifid_flush: got %b expected 1", bus.ifid_flush); end
      tests++; if (bus.idex_flush !== 1'b1) begin fails++; $display("FAIL redir_idex_flush: got %b expected 1", bus.idex_flush); end
      tests++; if (bus.pc_en !== 1'b1) begin fails++; $display("FAIL redir_pc_en: got %b expected 1", bus.pc_en); end
      tests++; if (bus.ifid_en !== 1'b1) begin fails++; $display("FAIL redir_ifid_en: got %b expected 1", bus.ifid_en); end
      tick();
      idle_inputs();
      #2;
      tests++; if (bus.pc_en !== 1'b1) begin fails++; $display("FAIL redir_next_pc_en: got %b expected 1", bus.pc_en); end
      tests++; if (bus.ifid_flush !== 1'b0) begin fails++; $display("FAIL redir_next_ifid_flush: got %b expected 0", bus.ifid_flush); end
      tick();
      bus.ex_rd = 5'd3; bus.ex_reg_write = 1'b1; bus.id_rs1 = 5'd3; bus.id_rs1_used = 1'b1;
      #2;
      tests++; if (bus.pc_en !== (FWD ? 1'b1 : 1'b0)) begin fails++; $display("FAIL redir_haz_c0_pc_en: got %b expected %b", bus.pc_en, FWD ? 1'b1 : 1'b0); end
      tick();
      bus.ex_reg_write = 1'b0; bus.ex_redirect = 1'b1;
      #2;
      tests++; if (bus.pc_en !== 1'b1) begin fails++; $display("FAIL redir_haz_c1_pc_en: got %b expected 1", bus.pc_en); end
      tests++; if (bus.ifid_flush !== 1'b1) begin fails++; $display("FAIL redir_haz_c1_ifid_flush: got %b expected 1", bus.ifid_flush); end
      tick();
      idle_inputs();
      #2;
      tests++; if (bus.pc_en !== 1'b1) begin fails++; $display("FAIL redir_haz_c2_pc_en: got %b expected 1", bus.pc_en); end
      tests++; if (bus.stall_cycles !== (FWD ? 32'd0 : 32'd1)) begin fails++; $display("FAIL redir_stall_cycles: got %0d expected %0d", bus.stall_cycles, FWD ? 0 : 1); end
      $display("[TB] redirect: flush beats RAW stall and HAZ_STALL");
   endtask

   task automatic test_mem_wait();
      do_reset();
      bus.ex_rd = 5'd5; bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1;
      bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1;
      #2;
      tests++; if (bus.pc_en !== 1'b0) begin fails++; $display("FAIL mw_c0_pc_en: got %b expected 0", bus.pc_en); end
      tick();
      bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0; bus.mem_rd = 5'd5; bus.mem_reg_write = 1'b1;
      bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         tests++; if ({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en} !== 5'b00000) begin
            fails++; $display("FAIL mw_wait%0d_enables: got %b expected 00000", i, {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en});
         end
         tests++; if ({bus.ifid_flush, bus.idex_flush} !== 2'b00) begin
            fails++; $display("FAIL mw_wait%0d_flushes: got %b expected 00", i, {bus.ifid_flush, bus.idex_flush});
         end
         tick();
      end
      bus.mem_ready = 1'b1;
      #2;
      tests++; if (bus.pc_en !== (FWD ? 1'b1 : 1'b0)) begin fails++; $display("FAIL mw_ready_pc_en: got %b expected %b", bus.pc_en, FWD ? 1'b1 : 1'b0); end
      tests++; if (bus.memwb_en !== 1'b1) begin fails++; $display("FAIL mw_ready_memwb_en: got %b expected 1", bus.memwb_en); end
      tests++; if (bus.idex_flush !== (FWD ? 1'b0 : 1'b1)) begin fails++; $display("FAIL mw_ready_idex_flush: got %b expected %b", bus.idex_flush, FWD ? 1'b0 : 1'b1); end
      tick();
      bus.mem_req = 1'b0; bus.mem_ready = 1'b0; bus.mem_reg_write = 1'b0; bus.wb_rd = 5'd5; bus.wb_reg_write = 1'b1;
      #2;
      tests++; if (bus.pc_en !== 1'b1) begin fails++; $display("FAIL mw_after_pc_en: got %b expected 1", bus.pc_en); end
      tests++; if (bus.stall_cycles !== (FWD ? 32'd4 : 32'd5)) begin fails++; $display("FAIL mw_stall_cycles: got %0d expected %0d", bus.stall_cycles, FWD ? 4 : 5); end
      $display("[TB] mem_wait: 3-cycle wait inside a stall done");
   endtask

   task automatic test_rst_mid_wait();
      do_reset();
      bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
      #2;
      tests++; if (bus.pc_en !== 1'b0) begin fails++; $display("FAIL rmw_c0_pc_en: got %b expected 0", bus.pc_en); end
      tick();
      #2;
      tests++; if (bus.stall_cycles !== 32'd1) begin fails++; $display("FAIL rmw_c1_stall_cycles: got %0d expected 1", bus.stall_cycles); end
      rst = 1'b1;
      #1;
      tests++; if (bus.pc_en !== 1'b1) begin fails++; $display("FAIL rmw_rst_pc_en: got %b expected 1", bus.pc_en); end
      tests++; if (bus.memwb_en !== 1'b1) begin fails++; $display("FAIL rmw_rst_memwb_en: got %b expected 1", bus.memwb_en); end
      tests++; if (bus.stall_cycles !== 32'd0) begin fails++; $display("FAIL rmw_rst_stall_cycles: got %0d expected 0", bus.stall_cycles); end
      #1;
      rst = 1'b0;
      bus.mem_req = 1'b0;
      tick();
      #2;
      tests++; if (bus.pc_en !== 1'b1) begin fails++; $display("FAIL rmw_after_pc_en: got %b expected 1", bus.pc_en); end
      tests++; if (bus.stall_cycles !== 32'd0) begin fails++; $display("FAIL rmw_after_stall_cycles: got %0d expected 0", bus.stall_cycles); end
      $display("[TB] rst_mid_wait: async reset during memory wait done");
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_load_use();
      test_alu_raw();
      test_mem_only();
      test_x0_and_unused();
      test_redirect();
      test_mem_wait();
      test_rst_mid_wait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
